axi_lite_slave_mem: RTL and testbench

Parametrised AXI-lite slave backed by a register array, for use as a bus-side memory endpoint and as the reference responder for driver/monitor benches. Independent write path (AW/W/B) and read path (AR/R), each with one transaction outstanding. Adds ID echo, byte strobes, address-range checking with SLVERR, and full back-pressure handling.

---
 rtl/axi_lite_pkg.sv | 35 +++
 rtl/axi_lite_slv_regarray.sv | 39 +++
 rtl/axi_lite_slave_mem.sv | 198 +++++++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI-lite slave memory: response codes,
// write/read FSM state encodings and the address range check.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    localparam int ADDR_CMP_W = 128;

    // Wide comparison so any practical address width and array size fit without overflow.
    function automatic logic addr_in_range(input logic [ADDR_CMP_W-1:0] addr,
                                           input int unsigned depth,
                                           input int unsigned bytes);
        logic [ADDR_CMP_W-1:0] limit;
        limit = ADDR_CMP_W'(depth) * ADDR_CMP_W'(bytes);
        return addr < limit;
    endfunction

endpackage

// File: rtl/axi_lite_slv_regarray.sv
// Byte-strobed word storage with asynchronous clear, one synchronous write
// port and one combinational read port.
module axi_lite_slv_regarray
    import axi_lite_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int BYTES = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              arst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BYTES-1:0]  wr_strb,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI-lite slave memory endpoint with independent single-outstanding write and
// read paths. Optional privilege check enabled by AXI_LITE_SLV_PROT_CHK_EN.
module axi_lite_slave_mem
    import axi_lite_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 16
) (
    input  logic                aclk,
    input  logic                arst_n,
    input  logic [ADDR_W-1:0]   AWAddr,
    input  logic                AWValid,
    input  logic [ID_W-1:0]     AWID,
    input  logic [2:0]          AWProt,
    output logic                AWReady,
    input  logic [DATA_W-1:0]   WData,
    input  logic [DATA_W/8-1:0] WStrb,
    input  logic                WValid,
    output logic                WReady,
    output logic                BValid,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BResp,
    input  logic                BReady,
    input  logic [ADDR_W-1:0]   ARAddr,
    input  logic                ARValid,
    input  logic [ID_W-1:0]     ARID,
    input  logic [2:0]          ARProt,
    output logic                ARReady,
    output logic [DATA_W-1:0]   RData,
    output logic [ID_W-1:0]     RID,
    output logic [1:0]          RResp,
    output logic                RValid,
    input  logic                RReady
);

    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [ADDR_W-1:0] aw_addr_q;
    logic [ID_W-1:0]   aw_id_q;
    logic [2:0]        aw_prot_q;
    logic [DATA_W-1:0] w_data_q;
    logic [BYTES-1:0]  w_strb_q;

    logic              aw_hs, w_hs, ar_hs;
    logic [ADDR_W-1:0] eff_addr;
    logic [ID_W-1:0]   eff_id;
    logic [2:0]        eff_prot;
    logic [DATA_W-1:0] eff_data;
    logic [BYTES-1:0]  eff_strb;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_priv_err, rd_priv_err;
    logic              wr_ok, rd_ok, commit;
    logic [DATA_W-1:0] arr_rd_data;

    assign aw_hs = AWValid && AWReady;
    assign w_hs  = WValid && WReady;
    assign ar_hs = ARValid && ARReady;

    // The commit edge may coincide with the last handshake, so use live bus values then.
    assign eff_addr = aw_hs ? AWAddr : aw_addr_q;
    assign eff_id   = aw_hs ? AWID   : aw_id_q;
    assign eff_prot = aw_hs ? AWProt : aw_prot_q;
    assign eff_data = w_hs  ? WData  : w_data_q;
    assign eff_strb = w_hs  ? WStrb  : w_strb_q;

    assign wr_idx = eff_addr[LSB +: IDX_W];
    assign rd_idx = ARAddr[LSB +: IDX_W];

`ifdef AXI_LITE_SLV_PROT_CHK_EN
    assign wr_priv_err = wr_idx[IDX_W-1] && !eff_prot[0];
    assign rd_priv_err = rd_idx[IDX_W-1] && !ARProt[0];
`else
    logic prot_unused;
    assign prot_unused = ^{eff_prot, ARProt};
    assign wr_priv_err = 1'b0;
    assign rd_priv_err = 1'b0;
`endif

    assign wr_ok  = addr_in_range(ADDR_CMP_W'(eff_addr), DEPTH, BYTES) && !wr_priv_err;
    assign rd_ok  = addr_in_range(ADDR_CMP_W'(ARAddr), DEPTH, BYTES) && !rd_priv_err;
    assign commit = (wr_next == WR_RESP) && (wr_state != WR_RESP);

    axi_lite_slv_regarray #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regarray (
        .aclk    (aclk),
        .arst_n  (arst_n),
        .wr_en   (commit && wr_ok),
        .wr_idx  (wr_idx),
        .wr_data (eff_data),
        .wr_strb (eff_strb),
        .rd_idx  (rd_idx),
        .rd_data (arr_rd_data)
    );

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        AWReady = 1'b0;
        WReady  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                AWReady = 1'b1;
                WReady  = 1'b1;
                if (AWValid && WValid) wr_next = WR_RESP;
                else if (AWValid)      wr_next = WR_WAIT_W;
                else if (WValid)       wr_next = WR_WAIT_AW;
            end
            WR_WAIT_W: begin
                WReady = 1'b1;
                if (WValid) wr_next = WR_RESP;
            end
            WR_WAIT_AW: begin
                AWReady = 1'b1;
                if (AWValid) wr_next = WR_RESP;
            end
            WR_RESP: begin
                if (BReady) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        ARReady = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                ARReady = 1'b1;
                if (ARValid) rd_next = RD_DATA;
            end
            RD_DATA: begin
                if (RReady) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    assign BValid = (wr_state == WR_RESP);
    assign RValid = (rd_state == RD_DATA);

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            aw_prot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            BID       <= '0;
            BResp     <= OKAY;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= AWAddr;
                aw_id_q   <= AWID;
                aw_prot_q <= AWProt;
            end
            if (w_hs) begin
                w_data_q <= WData;
                w_strb_q <= WStrb;
            end
            if (commit) begin
                BID   <= eff_id;
                BResp <= wr_ok ? OKAY : SLVERR;
            end
        end
    end

    // Array read happens on the handshake edge, so a same-cycle commit is not yet visible.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            RData <= '0;
            RID   <= '0;
            RResp <= OKAY;
        end else if (ar_hs) begin
            RData <= rd_ok ? arr_rd_data : '0;
            RID   <= ARID;
            RResp <= rd_ok ? OKAY : SLVERR;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Self-checking bench for axi_lite_slave_mem: directed scenarios plus random
// traffic against a byte-level behavioural memory model.
module tb_axi_lite_slave_mem;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 16;

    logic              aclk = 1'b0;
    logic              arst_n;
    logic [ADDR_W-1:0] AWAddr;
    logic              AWValid;
    logic [ID_W-1:0]   AWID;
    logic [2:0]        AWProt;
    logic              AWReady;
    logic [DATA_W-1:0] WData;
    logic [7:0]        WStrb;
    logic              WValid;
    logic              WReady;
    logic              BValid;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BResp;
    logic              BReady;
    logic [ADDR_W-1:0] ARAddr;
    logic              ARValid;
    logic [ID_W-1:0]   ARID;
    logic [2:0]        ARProt;
    logic              ARReady;
    logic [DATA_W-1:0] RData;
    logic [ID_W-1:0]   RID;
    logic [1:0]        RResp;
    logic              RValid;
    logic              RReady;

    int errors = 0;
    int checks = 0;

    logic [63:0] mem_model [DEPTH];

    axi_lite_slave_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .ID_W   (ID_W),
        .DEPTH  (DEPTH)
    ) dut (
        .aclk    (aclk),
        .arst_n  (arst_n),
        .AWAddr  (AWAddr),
        .AWValid (AWValid),
        .AWID    (AWID),
        .AWProt  (AWProt),
        .AWReady (AWReady),
        .WData   (WData),
        .WStrb   (WStrb),
        .WValid  (WValid),
        .WReady  (WReady),
        .BValid  (BValid),
        .BID     (BID),
        .BResp   (BResp),
        .BReady  (BReady),
        .ARAddr  (ARAddr),
        .ARValid (ARValid),
        .ARID    (ARID),
        .ARProt  (ARProt),
        .ARReady (ARReady),
        .RData   (RData),
        .RID     (RID),
        .RResp   (RResp),
        .RValid  (RValid),
        .RReady  (RReady)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Memory is 16 words of 8 bytes, i.e. byte addresses 0..127; upper half starts at 64.
    function automatic bit model_access_bad(input logic [63:0] addr, input logic [2:0] prot);
        bit bad;
        bad = (addr >= 64'd128);
`ifdef AXI_LITE_SLV_PROT_CHK_EN
        if (addr >= 64'd64 && addr < 64'd128 && !prot[0]) bad = 1'b1;
`else
        if (prot === 3'bxxx) bad = 1'b1;
`endif
        return bad;
    endfunction

    task automatic model_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                               input logic [2:0] prot, output logic [1:0] resp);
        int word;
        word = int'(addr / 64'd8) % DEPTH;
        if (model_access_bad(addr, prot)) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) mem_model[word][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    task automatic model_read(input logic [63:0] addr, input logic [2:0] prot,
                              output logic [63:0] data, output logic [1:0] resp);
        int word;
        word = int'(addr / 64'd8) % DEPTH;
        if (model_access_bad(addr, prot)) begin
            data = 64'd0;
            resp = 2'b10;
        end else begin
            data = mem_model[word];
            resp = 2'b00;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 64'd0;
    endtask

    // One complete write (AW and W together) or read transaction, checked against the model.
    task automatic applyStimulus(input bit is_write, input logic [63:0] addr, input logic [63:0] data,
                                 input logic [7:0] strb, input logic [3:0] id, input logic [2:0] prot);
        logic [1:0]  exp_resp;
        logic [63:0] exp_data;
        if (is_write) begin
            model_write(addr, data, strb, prot, exp_resp);
            AWAddr = addr; AWID = id; AWProt = prot; AWValid = 1'b1;
            WData = data; WStrb = strb; WValid = 1'b1;
            checkOutput("wr_awready", AWReady, 1);
            checkOutput("wr_wready", WReady, 1);
            @(posedge aclk); #1;
            AWValid = 1'b0; WValid = 1'b0;
            checkOutput("wr_bvalid", BValid, 1);
            checkOutput("wr_bid", BID, id);
            checkOutput("wr_bresp", BResp, exp_resp);
            BReady = 1'b1;
            @(posedge aclk); #1;
            BReady = 1'b0;
            checkOutput("wr_bvalid_clr", BValid, 0);
        end else begin
            model_read(addr, prot, exp_data, exp_resp);
            ARAddr = addr; ARID = id; ARProt = prot; ARValid = 1'b1;
            checkOutput("rd_arready", ARReady, 1);
            @(posedge aclk); #1;
            ARValid = 1'b0;
            checkOutput("rd_rvalid", RValid, 1);
            checkOutput("rd_rdata", RData, exp_data);
            checkOutput("rd_rid", RID, id);
            checkOutput("rd_rresp", RResp, exp_resp);
            RReady = 1'b1;
            @(posedge aclk); #1;
            RReady = 1'b0;
            checkOutput("rd_rvalid_clr", RValid, 0);
        end
    endtask

    initial begin
        logic [63:0] old_data, new_data, exp_data;
        logic [1:0]  exp_resp, exp_rresp;

        arst_n = 1'b0;
        AWAddr = '0; AWValid = 1'b0; AWID = '0; AWProt = '0;
        WData = '0; WStrb = '0; WValid = 1'b0; BReady = 1'b0;
        ARAddr = '0; ARValid = 1'b0; ARID = '0; ARProt = '0; RReady = 1'b0;
        model_clear();

        repeat (2) @(posedge aclk);
        #1;
        checkOutput("rst_awready", AWReady, 1);
        checkOutput("rst_wready", WReady, 1);
        checkOutput("rst_arready", ARReady, 1);
        checkOutput("rst_bvalid", BValid, 0);
        checkOutput("rst_rvalid", RValid, 0);
        checkOutput("rst_bid", BID, 0);
        checkOutput("rst_rdata", RData, 0);
        arst_n = 1'b1;
        @(posedge aclk); #1;

        $display("[TB] same-cycle AW/W write and readback");
        applyStimulus(1'b1, 64'h08, 64'h1122334455667788, 8'hFF, 4'd3, 3'd0);
        applyStimulus(1'b0, 64'h08, 64'h0, 8'h0, 4'd5, 3'd0);

        $display("[TB] W two cycles ahead of AW with partial strobe");
        WData = 64'hAAAAAAAABBBBBBBB; WStrb = 8'h0F; WValid = 1'b1;
        @(posedge aclk); #1;
        WValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("waw_awready", AWReady, 1);
            checkOutput("waw_wready", WReady, 0);
            checkOutput("waw_bvalid", BValid, 0);
            @(posedge aclk); #1;
        end
        model_write(64'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F, 3'd0, exp_resp);
        AWAddr = 64'h10; AWID = 4'd7; AWProt = 3'd0; AWValid = 1'b1;
        @(posedge aclk); #1;
        AWValid = 1'b0;
        checkOutput("waw_bvalid_set", BValid, 1);
        checkOutput("waw_bid", BID, 7);
        checkOutput("waw_bresp", BResp, exp_resp);
        BReady = 1'b1;
        @(posedge aclk); #1;
        BReady = 1'b0;
        ARAddr = 64'h10; ARID = 4'd1; ARProt = 3'd0; ARValid = 1'b1;
        @(posedge aclk); #1;
        ARValid = 1'b0;
        checkOutput("waw_readback", RData, 64'h00000000BBBBBBBB);
        RReady = 1'b1;
        @(posedge aclk); #1;
        RReady = 1'b0;

        $display("[TB] AW ahead of W");
        model_write(64'h28, 64'hCAFEF00D12345678, 8'hF0, 3'd0, exp_resp);
        AWAddr = 64'h28; AWID = 4'd2; AWValid = 1'b1;
        @(posedge aclk); #1;
        AWValid = 1'b0;
        checkOutput("wwa_awready", AWReady, 0);
        checkOutput("wwa_wready", WReady, 1);
        WData = 64'hCAFEF00D12345678; WStrb = 8'hF0; WValid = 1'b1;
        @(posedge aclk); #1;
        WValid = 1'b0;
        checkOutput("wwa_bvalid", BValid, 1);
        checkOutput("wwa_bresp", BResp, exp_resp);
        BReady = 1'b1;
        @(posedge aclk); #1;
        BReady = 1'b0;
        applyStimulus(1'b0, 64'h2C, 64'h0, 8'h0, 4'd4, 3'd0);

        $display("[TB] out-of-range access");
        applyStimulus(1'b1, 64'h80, 64'hDEADBEEFDEADBEEF, 8'hFF, 4'd8, 3'd0);
        applyStimulus(1'b0, 64'h80, 64'h0, 8'h0, 4'd9, 3'd0);
        applyStimulus(1'b0, 64'h00, 64'h0, 8'h0, 4'd10, 3'd0);

        $display("[TB] zero strobe write");
        applyStimulus(1'b1, 64'h08, 64'h5555555555555555, 8'h00, 4'd11, 3'd0);
        applyStimulus(1'b0, 64'h08, 64'h0, 8'h0, 4'd12, 3'd0);

        $display("[TB] back-pressure with same-cycle read of committed word");
        model_read(64'h08, 3'd0, old_data, exp_rresp);
        new_data = 64'h0123456789ABCDEF;
        model_write(64'h08, new_data, 8'hFF, 3'd0, exp_resp);
        AWAddr = 64'h08; AWID = 4'd6; AWProt = 3'd0; AWValid = 1'b1;
        WData = new_data; WStrb = 8'hFF; WValid = 1'b1;
        ARAddr = 64'h08; ARID = 4'd9; ARProt = 3'd0; ARValid = 1'b1;
        @(posedge aclk); #1;
        AWValid = 1'b0; WValid = 1'b0; ARValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_bvalid", BValid, 1);
            checkOutput("bp_bid", BID, 6);
            checkOutput("bp_bresp", BResp, exp_resp);
            checkOutput("bp_awready", AWReady, 0);
            checkOutput("bp_wready", WReady, 0);
            if (i < 3) begin
                checkOutput("bp_rvalid", RValid, 1);
                checkOutput("bp_rdata_old", RData, old_data);
                checkOutput("bp_rid", RID, 9);
                checkOutput("bp_arready", ARReady, 0);
            end else begin
                checkOutput("bp_rvalid_clr", RValid, 0);
                checkOutput("bp_arready_back", ARReady, 1);
            end
            if (i == 2) RReady = 1'b1;
            if (i == 4) BReady = 1'b1;
            @(posedge aclk); #1;
            RReady = 1'b0;
            BReady = 1'b0;
        end
        checkOutput("bp_bvalid_clr", BValid, 0);
        applyStimulus(1'b0, 64'h08, 64'h0, 8'h0, 4'd13, 3'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 64'($urandom_range(0, 'h9F)),
                          {32'($urandom), 32'($urandom)}, 8'($urandom), 4'($urandom), 3'($urandom));
        end

`ifdef AXI_LITE_SLV_PROT_CHK_EN
        $display("[TB] privileged region");
        applyStimulus(1'b1, 64'h40, 64'h9999888877776666, 8'hFF, 4'd1, 3'b000);
        applyStimulus(1'b0, 64'h40, 64'h0, 8'h0, 4'd2, 3'b001);
        applyStimulus(1'b1, 64'h40, 64'h9999888877776666, 8'hFF, 4'd3, 3'b001);
        applyStimulus(1'b0, 64'h40, 64'h0, 8'h0, 4'd4, 3'b001);
        applyStimulus(1'b0, 64'h40, 64'h0, 8'h0, 4'd5, 3'b000);
`endif

        $display("[TB] reset during pending responses");
        AWAddr = 64'h18; AWID = 4'd14; AWValid = 1'b1;
        WData = 64'hFFFF0000FFFF0000; WStrb = 8'hFF; WValid = 1'b1;
        ARAddr = 64'h08; ARID = 4'd15; ARValid = 1'b1;
        @(posedge aclk); #1;
        AWValid = 1'b0; WValid = 1'b0; ARValid = 1'b0;
        checkOutput("mid_bvalid", BValid, 1);
        checkOutput("mid_rvalid", RValid, 1);
        #2;
        arst_n = 1'b0;
        #1;
        checkOutput("mid_rst_bvalid", BValid, 0);
        checkOutput("mid_rst_rvalid", RValid, 0);
        checkOutput("mid_rst_awready", AWReady, 1);
        checkOutput("mid_rst_wready", WReady, 1);
        checkOutput("mid_rst_arready", ARReady, 1);
        checkOutput("mid_rst_bid", BID, 0);
        checkOutput("mid_rst_rdata", RData, 0);
        model_clear();
        @(posedge aclk); #1;
        arst_n = 1'b1;
        @(posedge aclk); #1;
        for (int a = 0; a < DEPTH; a += 5) begin
            model_read(64'(a * 8), 3'd1, exp_data, exp_rresp);
            checkOutput("post_rst_model_zero", exp_data, 64'd0);
            applyStimulus(1'b0, 64'(a * 8), 64'h0, 8'h0, 4'(a), 3'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
